// File: rtl/sdc_arb_pkg.sv
// sdc_arb_pkg: shared state encoding, idle/reset constants and the default watchdog limit.
// The DRAIN state exists only when SDC_ARB_TIMEOUT_EN is defined.
package sdc_arb_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
`ifdef SDC_ARB_TIMEOUT_EN
    , ST_DRAIN
`endif
  } state_e;
  localparam logic [7:0]  SDC_CMD_IDLE    = 8'hFF;
  localparam logic [31:0] SDC_ARG_IDLE    = 32'hFFFFFFFF;
  localparam logic [7:0]  SDC_CRC_IDLE    = 8'hFF;
  localparam logic [7:0]  SDC_RESP_NONE   = 8'hFF;
  localparam int          TIMEOUT_CYC_DEF = 2_700_000;
endpackage

// File: rtl/sdc_cmd_arbiter_if.sv
// sdc_cmd_arbiter_if: requester and command-engine signals of the arbiter.
// master: requesters + engine side; slave: arbiter side.
interface sdc_cmd_arbiter_if #(parameter int NREQ = 3);
  logic [NREQ-1:0]      i_req;
  logic [NREQ-1:0]      i_lock;
  logic [8*NREQ-1:0]    i_cmd;
  logic [32*NREQ-1:0]   i_arg;
  logic [8*NREQ-1:0]    i_crc;
  logic [NREQ-1:0]      o_ack;
  logic [NREQ-1:0]      o_done;
  logic [7:0]           o_response;
  logic                 o_timeout;
  logic                 o_busy;
  logic [7:0]           o_eng_cmd;
  logic [31:0]          o_eng_arg;
  logic [7:0]           o_eng_crc;
  logic                 o_eng_we;
  logic                 i_eng_done;
  logic [7:0]           i_eng_resp;
  modport master (
    output i_req, i_lock, i_cmd, i_arg, i_crc, i_eng_done, i_eng_resp,
    input  o_ack, o_done, o_response, o_timeout, o_busy,
           o_eng_cmd, o_eng_arg, o_eng_crc, o_eng_we
  );
  modport slave (
    input  i_req, i_lock, i_cmd, i_arg, i_crc, i_eng_done, i_eng_resp,
    output o_ack, o_done, o_response, o_timeout, o_busy,
           o_eng_cmd, o_eng_arg, o_eng_crc, o_eng_we
  );
endinterface

// File: rtl/sdc_rr_pick.sv
// sdc_rr_pick: combinational round-robin selector.
// req_i: request vector; ptr_i: first index to consider; gnt_o: one-hot winner; idx_o: winner index.
module sdc_rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  int k;
  // Scan offsets from farthest to nearest so the nearest set bit at/after ptr_i wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % NREQ;
      if (req_i[k]) begin
        gnt_o = {{(NREQ-1){1'b0}}, 1'b1} << k;
        idx_o = IW'(k);
      end
    end
  end
endmodule

// File: rtl/sdc_cmd_arbiter.sv
// sdc_cmd_arbiter: round-robin sharing of the SD SPI command engine between NREQ requesters.
// i_clk/i_rst: clock and asynchronous active-high reset; bus: requester + engine signals.
// Optional watchdog with DRAIN state: define SDC_ARB_TIMEOUT_EN (TIMEOUT_CYC cycles per command).
module sdc_cmd_arbiter
  import sdc_arb_pkg::*;
#(
  parameter int NREQ = 3
`ifdef SDC_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sdc_cmd_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_e          state_q;
  logic [IW-1:0]   g_q, p_q, pick_idx, src, gnext_d;
  logic [NREQ-1:0] pick_gnt, ack_q, done_q;
  logic [7:0]      cmd_q, crc_q, resp_q;
  logic [31:0]     arg_q;
  logic            we_q;
  sdc_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (bus.i_req),
    .ptr_i (p_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );
  // In HOLD only the locked requester may load a command.
  assign src     = (state_q == ST_HOLD) ? g_q : pick_idx;
  assign gnext_d = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
`ifdef SDC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] wdog_q;
  logic          tmo_q;
  assign bus.o_timeout = tmo_q;
`else
  assign bus.o_timeout = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      p_q     <= '0;
      cmd_q   <= SDC_CMD_IDLE;
      arg_q   <= SDC_ARG_IDLE;
      crc_q   <= SDC_CRC_IDLE;
      resp_q  <= SDC_RESP_NONE;
      we_q    <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
`ifdef SDC_ARB_TIMEOUT_EN
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      ack_q  <= '0;
      done_q <= '0;
`ifdef SDC_ARB_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if ((state_q == ST_IDLE) ? |pick_gnt : bus.i_req[g_q]) begin
            cmd_q   <= bus.i_cmd[8*src +: 8];
            arg_q   <= bus.i_arg[32*src +: 32];
            crc_q   <= bus.i_crc[8*src +: 8];
            g_q     <= src;
            state_q <= ST_ISSUE;
          end else if (state_q == ST_HOLD && !bus.i_lock[g_q]) begin
            p_q     <= gnext_d;
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          we_q       <= 1'b1;
          ack_q[g_q] <= 1'b1;
`ifdef SDC_ARB_TIMEOUT_EN
          wdog_q     <= '0;
`endif
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_eng_done) begin
            resp_q      <= bus.i_eng_resp;
            done_q[g_q] <= 1'b1;
            if (bus.i_lock[g_q]) state_q <= ST_HOLD;
            else begin
              p_q     <= gnext_d;
              state_q <= ST_IDLE;
            end
          end
`ifdef SDC_ARB_TIMEOUT_EN
          else if (wdog_q == CW'(TIMEOUT_CYC - 1)) begin
            resp_q      <= SDC_RESP_NONE;
            done_q[g_q] <= 1'b1;
            tmo_q       <= 1'b1;
            state_q     <= ST_DRAIN;
          end else wdog_q <= wdog_q + 1'b1;
`endif
        end
`ifdef SDC_ARB_TIMEOUT_EN
        // The engine still owes a done for the abandoned command; swallow it and drop any lock.
        ST_DRAIN: begin
          if (bus.i_eng_done) begin
            p_q     <= gnext_d;
            state_q <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus.o_ack      = ack_q;
  assign bus.o_done     = done_q;
  assign bus.o_response = resp_q;
  assign bus.o_busy     = state_q != ST_IDLE;
  assign bus.o_eng_cmd  = cmd_q;
  assign bus.o_eng_arg  = arg_q;
  assign bus.o_eng_crc  = crc_q;
  assign bus.o_eng_we   = we_q;
endmodule

// File: tb/tb_sdc_cmd_arbiter.sv
// tb_sdc_cmd_arbiter: scoreboard bench for sdc_cmd_arbiter with a simple command-engine model.
module tb_sdc_cmd_arbiter;
  localparam int NREQ = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sdc_cmd_arbiter_if #(.NREQ(NREQ)) bus ();
  sdc_cmd_arbiter #(
    .NREQ(NREQ)
`ifdef SDC_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );
  typedef struct {
    logic [2:0]  ack;
    logic [7:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  crc;
    int          cyc;
  } iss_t;
  typedef struct {
    logic [2:0] done;
    logic [7:0] resp;
    logic       tmo;
    int         cyc;
  } dn_t;
  iss_t exp_iss[$];
  dn_t  exp_dn[$];
  iss_t ei;
  dn_t  ed;
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Requester model: per-requester command table, request stays high until acked.
  logic [47:0]     cmd_tab [NREQ][8];
  int              req_cnt [NREQ] = '{default: 0};
  int              served  [NREQ] = '{default: 0};
  logic [NREQ-1:0] lock_v = '0;
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NREQ; k++) if (bus.o_ack[k]) served[k] <= served[k] + 1;
  end
  for (genvar k = 0; k < NREQ; k++) begin : g_req
    assign bus.i_req[k] = req_cnt[k] > served[k];
    assign {bus.i_cmd[8*k +: 8], bus.i_arg[32*k +: 32], bus.i_crc[8*k +: 8]} = cmd_tab[k][served[k] % 8];
  end
  assign bus.i_lock = lock_v;
  task automatic post(int k, logic [7:0] c, logic [31:0] a, logic [7:0] r);
    cmd_tab[k][req_cnt[k] % 8] = {c, a, r};
    req_cnt[k]++;
  endtask
  // Engine model: answers three cycles after the start pulse unless muted; kick forces a stray done.
  function automatic logic [7:0] resp_for(logic [7:0] c);
    case (c)
      8'h40, 8'h77, 8'h48: return 8'h01;
      8'h51, 8'h69:        return 8'h00;
      8'h58:               return 8'h05;
      default:             return 8'h04;
    endcase
  endfunction
  logic       mute = 1'b0;
  int         kick = 0;
  int         kicked = 0;
  int         eng_cnt = 0;
  logic [7:0] eng_cmd = 8'h00;
  logic       hit;
  initial begin
    bus.i_eng_done = 1'b0;
    bus.i_eng_resp = 8'h00;
    forever begin
      @(negedge clk);
      hit = kick != kicked;
      kicked = kick;
      bus.i_eng_done = 1'b0;
      if (rst) eng_cnt = 0;
      else if (bus.o_eng_we && !mute) begin
        eng_cnt = 3;
        eng_cmd = bus.o_eng_cmd;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.i_eng_done = 1'b1;
          bus.i_eng_resp = resp_for(eng_cmd);
        end
      end
      if (hit) begin
        bus.i_eng_done = 1'b1;
        bus.i_eng_resp = 8'h3C;
      end
    end
  end
  // Monitor: pops the scoreboard whenever a command is issued or completed.
  logic outst = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst) outst = 1'b0;
    else begin
      if (bus.o_eng_we) begin
        if (exp_iss.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_issue: got ack=%b cmd=%h required no issue", bus.o_ack, bus.o_eng_cmd);
        end else begin
          ei = exp_iss.pop_front();
          check("issue", {bus.o_ack, bus.o_eng_cmd, bus.o_eng_arg, bus.o_eng_crc}, {ei.ack, ei.cmd, ei.arg, ei.crc});
          if (ei.cyc >= 0) check("issue_cycle", cyc, ei.cyc);
          check("prev_done_before_ack", outst, 1'b0);
        end
        outst = 1'b1;
      end
      if (bus.o_done != '0) begin
        if (exp_dn.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=%b resp=%h required no done", bus.o_done, bus.o_response);
        end else begin
          ed = exp_dn.pop_front();
          check("done", {bus.o_done, bus.o_response, bus.o_timeout}, {ed.done, ed.resp, ed.tmo});
          if (ed.cyc >= 0) check("done_cycle", cyc, ed.cyc);
        end
        outst = 1'b0;
      end
    end
  end
  task automatic wait_idle(string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.o_busy && exp_iss.size() == 0 && exp_dn.size() == 0) break;
    end
    check(name, i < 300, 1'b1);
  endtask
  task automatic wait_done(string name, int k);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_done[k]) break;
    end
    check(name, i < 300, 1'b1);
  endtask
  task automatic wait_we(string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_eng_we) break;
    end
    check(name, i < 300, 1'b1);
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_eng_cmd"}, bus.o_eng_cmd, 8'hFF);
    check({tag, "_eng_arg"}, bus.o_eng_arg, 32'hFFFFFFFF);
    check({tag, "_eng_crc"}, bus.o_eng_crc, 8'hFF);
    check({tag, "_strobes"}, {bus.o_eng_we, bus.o_ack, bus.o_done, bus.o_timeout, bus.o_busy}, '0);
    check({tag, "_response"}, bus.o_response, 8'hFF);
  endtask
  int w;
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    // Single request from requester 1.
    @(negedge clk);
    exp_iss.push_back('{3'b010, 8'h40, 32'h0, 8'h95, cyc + 2});
    exp_dn.push_back('{3'b010, 8'h01, 1'b0, cyc + 6});
    post(1, 8'h40, 32'h0, 8'h95);
    @(negedge clk);
    check("busy_in_issue", bus.o_busy, 1'b1);
    wait_idle("single_idle");
    check("single_response_held", bus.o_response, 8'h01);
    // Contention from reset: grants 0, 1, 2.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_iss.push_back('{3'b001, 8'h40, 32'h0, 8'h95, cyc + 2});
    exp_iss.push_back('{3'b010, 8'h51, 32'h200, 8'h55, -1});
    exp_iss.push_back('{3'b100, 8'h58, 32'h400, 8'h6F, -1});
    exp_dn.push_back('{3'b001, 8'h01, 1'b0, -1});
    exp_dn.push_back('{3'b010, 8'h00, 1'b0, -1});
    exp_dn.push_back('{3'b100, 8'h05, 1'b0, -1});
    post(0, 8'h40, 32'h0, 8'h95);
    post(1, 8'h51, 32'h200, 8'h55);
    post(2, 8'h58, 32'h400, 8'h6F);
    wait_idle("contention_idle");
    // Lock: requester 0 issues two commands before pending requester 2.
    lock_v[0] = 1'b1;
    exp_iss.push_back('{3'b001, 8'h77, 32'h0, 8'h65, cyc + 2});
    exp_dn.push_back('{3'b001, 8'h01, 1'b0, cyc + 6});
    post(0, 8'h77, 32'h0, 8'h65);
    post(2, 8'h48, 32'h1AA, 8'h87);
    wait_done("lock_first_done", 0);
    check("busy_in_hold", bus.o_busy, 1'b1);
    exp_iss.push_back('{3'b001, 8'h69, 32'h40000000, 8'h77, cyc + 2});
    exp_dn.push_back('{3'b001, 8'h00, 1'b0, cyc + 6});
    post(0, 8'h69, 32'h40000000, 8'h77);
    wait_done("lock_second_done", 0);
    lock_v[0] = 1'b0;
    exp_iss.push_back('{3'b100, 8'h48, 32'h1AA, 8'h87, cyc + 3});
    exp_dn.push_back('{3'b100, 8'h01, 1'b0, cyc + 7});
    wait_idle("lock_idle");
`ifdef SDC_ARB_TIMEOUT_EN
    // Watchdog: engine stays silent, then a late done is swallowed.
    mute = 1'b1;
    lock_v[0] = 1'b1;
    exp_iss.push_back('{3'b001, 8'h4D, 32'h0, 8'h0D, cyc + 2});
    post(0, 8'h4D, 32'h0, 8'h0D);
    wait_we("timeout_we");
    exp_dn.push_back('{3'b001, 8'hFF, 1'b1, cyc + 16});
    wait_done("timeout_done", 0);
    repeat (3) @(negedge clk);
    check("busy_in_drain", bus.o_busy, 1'b1);
    kick++;
    mute = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_released", bus.o_busy, 1'b0);
    check("drain_response_kept", bus.o_response, 8'hFF);
    lock_v[0] = 1'b0;
`endif
    // Plain command from requester 1 leaves the pointer at 2.
    exp_iss.push_back('{3'b010, 8'h50, 32'h200, 8'h15, cyc + 2});
    exp_dn.push_back('{3'b010, 8'h04, 1'b0, cyc + 6});
    post(1, 8'h50, 32'h200, 8'h15);
    wait_idle("ptr_idle");
    // Reset while waiting for the engine.
    mute = 1'b1;
    exp_iss.push_back('{3'b100, 8'h4C, 32'h12345678, 8'h2B, cyc + 2});
    post(2, 8'h4C, 32'h12345678, 8'h2B);
    wait_we("rst_wait_we");
    @(negedge clk);
    check("busy_before_reset", bus.o_busy, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mute = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_reset", bus.o_busy, 1'b0);
    exp_iss.push_back('{3'b010, 8'h4A, 32'h0, 8'h11, cyc + 2});
    exp_iss.push_back('{3'b100, 8'h4B, 32'h1, 8'h22, -1});
    exp_dn.push_back('{3'b010, 8'h04, 1'b0, cyc + 6});
    exp_dn.push_back('{3'b100, 8'h04, 1'b0, -1});
    post(1, 8'h4A, 32'h0, 8'h11);
    post(2, 8'h4B, 32'h1, 8'h22);
    wait_idle("post_reset_idle");
    w = exp_iss.size();
    check("issue_queue_empty", w, 0);
    w = exp_dn.size();
    check("done_queue_empty", w, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish before 100000");
    $fatal(1);
  end
endmodule
